// File: rtl/bus_slave_timer_pkg.sv
// Shared constants for the bus-slave interval timer: bus signalling levels,
// register word indices and control/interrupt bit positions.
package bus_slave_timer_pkg;

    // Bus geometry
    localparam int TIMER_DATA_W = 32;
    localparam int TIMER_REG_AW = 2;

    // Bus direction and active-low strobe levels
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Register word indices inside the slave
    typedef enum logic [1:0] {
        TIMER_ADDR_CTRL    = 2'd0,
        TIMER_ADDR_INTR    = 2'd1,
        TIMER_ADDR_EXPR    = 2'd2,
        TIMER_ADDR_COUNTER = 2'd3
    } timer_addr_e;

    // Bit locations within CTRL and INTR
    localparam int TIMER_START_LOC = 0;
    localparam int TIMER_MODE_LOC  = 1;
    localparam int TIMER_IRQ_LOC   = 0;

endpackage

// File: rtl/bus_slave_timer.sv
// Bus-slave interval timer. Decodes one chip-select, exposes CTRL/INTR/EXPR/
// COUNTER, counts clock cycles while started and raises irq when COUNTER
// reaches EXPR. Every accepted access is answered one cycle later.
module bus_slave_timer
    import bus_slave_timer_pkg::*;
#(
    parameter int DATA_W = TIMER_DATA_W,
    parameter int REG_AW = TIMER_REG_AW
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              rdy_,
    output logic              irq
);

    logic              r_start;
    logic              r_periodic;
    logic              r_irq;
    logic [DATA_W-1:0] r_expr;
    logic [DATA_W-1:0] r_counter;
    logic              r_rdy_n;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_req;
    logic              w_wr;
    logic              w_expire;
    logic [DATA_W-1:0] w_rd_sel;

    assign w_req    = (cs_ == ENABLE_) && (as_ == ENABLE_);
    assign w_wr     = w_req && (rw == WRITE);
    assign w_expire = r_start && (r_counter == r_expr);

    // Select the register image returned by a read (pre-update values)
    always_comb begin
        w_rd_sel = {DATA_W{1'b0}};
        case (addr)
            REG_AW'(TIMER_ADDR_CTRL): begin
                w_rd_sel[TIMER_START_LOC] = r_start;
                w_rd_sel[TIMER_MODE_LOC]  = r_periodic;
            end
            REG_AW'(TIMER_ADDR_INTR): begin
                w_rd_sel[TIMER_IRQ_LOC] = r_irq;
            end
            REG_AW'(TIMER_ADDR_EXPR): begin
                w_rd_sel = r_expr;
            end
            REG_AW'(TIMER_ADDR_COUNTER): begin
                w_rd_sel = r_counter;
            end
            default: begin
                w_rd_sel = {DATA_W{1'b0}};
            end
        endcase
    end

    // Bus response: one-cycle rdy_ pulse per accepted access, read data only on reads
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_rdy_n   <= DISABLE_;
            r_rd_data <= {DATA_W{1'b0}};
        end else if (w_req) begin
            r_rdy_n   <= ENABLE_;
            r_rd_data <= (rw == READ) ? w_rd_sel : {DATA_W{1'b0}};
        end else begin
            r_rdy_n   <= DISABLE_;
            r_rd_data <= {DATA_W{1'b0}};
        end
    end

    // Timer state: bus writes take priority over hardware updates, except that
    // an expiry always leaves IRQ set
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_start    <= 1'b0;
            r_periodic <= 1'b0;
            r_irq      <= 1'b0;
            r_expr     <= {DATA_W{1'b0}};
            r_counter  <= {DATA_W{1'b0}};
        end else begin
            // CTRL: software write overrides the one-shot auto-stop
            if (w_wr && (addr == REG_AW'(TIMER_ADDR_CTRL))) begin
                r_start    <= wrData[TIMER_START_LOC];
                r_periodic <= wrData[TIMER_MODE_LOC];
            end else if (w_expire && !r_periodic) begin
                r_start <= 1'b0;
            end else begin
                r_start <= r_start;
            end

            // INTR: hardware set beats software clear; software cannot set
            if (w_expire) begin
                r_irq <= 1'b1;
            end else if (w_wr && (addr == REG_AW'(TIMER_ADDR_INTR)) &&
                         !wrData[TIMER_IRQ_LOC]) begin
                r_irq <= 1'b0;
            end else begin
                r_irq <= r_irq;
            end

            // EXPR: plain read/write register
            if (w_wr && (addr == REG_AW'(TIMER_ADDR_EXPR))) begin
                r_expr <= wrData;
            end else begin
                r_expr <= r_expr;
            end

            // COUNTER: bus write beats increment and expiry clear
            if (w_wr && (addr == REG_AW'(TIMER_ADDR_COUNTER))) begin
                r_counter <= wrData;
            end else if (w_expire) begin
                r_counter <= {DATA_W{1'b0}};
            end else if (r_start) begin
                r_counter <= r_counter + {{(DATA_W-1){1'b0}}, 1'b1};
            end else begin
                r_counter <= r_counter;
            end
        end
    end

    assign rdData = r_rd_data;
    assign rdy_   = r_rdy_n;
    assign irq    = r_irq;

endmodule

// File: tb/tb_bus_slave_timer.sv
// Directed bench for bus_slave_timer: a register-level reference model is
// compared against the DUT outputs on every falling edge, and hand-computed
// literal expectations pin the model at the interesting points.
module tb_bus_slave_timer;

    logic        clk;
    logic        reset_;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        rdy_;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    bus_slave_timer dut (
        .clk    (clk),
        .reset_ (reset_),
        .cs_    (cs_),
        .as_    (as_),
        .rw     (rw),
        .addr   (addr),
        .wrData (wrData),
        .rdData (rdData),
        .rdy_   (rdy_),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register file plus bus response
    typedef struct packed {
        logic        start;
        logic        periodic;
        logic        irq;
        logic [31:0] expr;
        logic [31:0] counter;
        logic        rdy_n;
        logic [31:0] rd_data;
    } mdl_t;

    mdl_t m;

    function automatic logic [31:0] peek(input mdl_t c, input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: v = {30'd0, c.periodic, c.start};
            2'd1: v = {31'd0, c.irq};
            2'd2: v = c.expr;
            default: v = c.counter;
        endcase
        return v;
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input logic rst_n, input logic cs_n,
                                        input logic as_n, input logic r, input logic [1:0] a,
                                        input logic [31:0] d);
        mdl_t n;
        logic req;
        logic hit;
        n = c;
        if (!rst_n) begin
            n = '0;
            n.rdy_n = 1'b1;
            return n;
        end
        req = !cs_n && !as_n;
        hit = c.start && (c.counter == c.expr);
        n.rdy_n = !req;
        n.rd_data = (req && r) ? peek(c, a) : 32'd0;
        // hardware behaviour of the timer this cycle
        if (c.start) n.counter = hit ? 32'd0 : c.counter + 32'd1;
        if (hit) begin
            n.irq = 1'b1;
            if (!c.periodic) n.start = 1'b0;
        end
        // software write layered on top
        if (req && !r) begin
            case (a)
                2'd0: begin n.start = d[0]; n.periodic = d[1]; end
                2'd1: if (!d[0] && !hit) n.irq = 1'b0;
                2'd2: n.expr = d;
                default: n.counter = d;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, reset_, cs_, as_, rw, addr, wrData);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model rdy_",   {31'd0, rdy_}, {31'd0, m.rdy_n});
            check("model rdData", rdData, m.rd_data);
            check("model irq",    {31'd0, irq},  {31'd0, m.irq});
        end
    end

    task automatic bus_req(input logic r, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wrData = d;
        @(negedge clk);
        q = rdData;
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wrData = 32'd0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_req(1'b0, a, d, q);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] q);
        bus_req(1'b1, a, 32'd0, q);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] q;
        logic [31:0] exp_oneshot [7];
        logic [31:0] exp_wrap [4];
        exp_oneshot = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
        exp_wrap    = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};

        reset_ = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 2'd0; wrData = 32'd0;

        // 1: reset
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset rdy_",   {31'd0, rdy_}, 32'd1);
        check("reset irq",    {31'd0, irq},  32'd0);
        check("reset rdData", rdData, 32'd0);
        reset_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), q);
            check("reset reg read", q, 32'd0);
            check("read rdy_ low", {31'd0, rdy_}, 32'd0);
        end

        // 2: one-shot, EXPR=5
        wr(2'd2, 32'd5);
        wr(2'd0, 32'd1);
        for (int i = 0; i < 7; i++) begin
            rd(2'd3, q);
            check("oneshot count", q, exp_oneshot[i]);
            if (i == 4) check("oneshot irq before", {31'd0, irq}, 32'd0);
            if (i == 5) check("oneshot irq at expiry", {31'd0, irq}, 32'd1);
        end
        rd(2'd0, q);
        check("oneshot ctrl cleared", q, 32'd0);
        rd(2'd3, q);
        check("oneshot counter holds", q, 32'd0);
        wr(2'd1, 32'd0);
        check("irq sw clear", {31'd0, irq}, 32'd0);

        // 3: periodic, EXPR=3
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd3);
        for (int i = 0; i < 4; i++) begin
            rd(2'd3, q);
            check("periodic count", q, 32'(i));
        end
        check("periodic irq", {31'd0, irq}, 32'd1);
        wr(2'd1, 32'd0);
        check("periodic irq cleared", {31'd0, irq}, 32'd0);
        rd(2'd3, q);
        check("periodic count wrap1", q, 32'd1);
        rd(2'd3, q);
        check("periodic count wrap2", q, 32'd2);
        wr(2'd1, 32'd0);
        check("clear vs expiry irq", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'd0);
        rd(2'd3, q);
        check("stopped counter", q, 32'd1);

        // 4: bus timing
        rd(2'd2, q);
        check("timing rdData", q, 32'd3);
        check("timing rdy_ low", {31'd0, rdy_}, 32'd0);
        @(negedge clk);
        check("timing rdy_ back high", {31'd0, rdy_}, 32'd1);
        check("timing rdData zero", rdData, 32'd0);
        cs_ = 1'b1; as_ = 1'b0; rw = 1'b1; addr = 2'd2;
        @(negedge clk);
        check("no cs rdy_", {31'd0, rdy_}, 32'd1);
        as_ = 1'b1;

        // 5: wrap
        wr(2'd1, 32'd0);
        wr(2'd3, 32'hFFFF_FFFE);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd(2'd3, q);
            check("wrap count", q, exp_wrap[i]);
            check("wrap irq", {31'd0, irq}, (i == 3) ? 32'd1 : 32'd0);
        end

        // 6: COUNTER write on a periodic expiry cycle
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd3);
        rd(2'd3, q);
        rd(2'd3, q);
        wr(2'd3, 32'h10);
        check("conflict irq", {31'd0, irq}, 32'd1);
        rd(2'd3, q);
        check("conflict counter", q, 32'h10);

        // reserved CTRL bits ignore writes
        wr(2'd0, 32'hFFFF_FFFE);
        rd(2'd0, q);
        check("ctrl reserved bits", q, 32'd2);

        // reset with a pending read: response dropped
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd2;
        @(negedge clk);
        reset_ = 1'b0; cs_ = 1'b1; as_ = 1'b1;
        @(negedge clk);
        check("reset mid access rdy_", {31'd0, rdy_}, 32'd1);
        check("reset mid access rdData", rdData, 32'd0);
        check("reset mid access irq", {31'd0, irq}, 32'd0);
        reset_ = 1'b1;
        rd(2'd2, q);
        check("expr after reset", q, 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
